// File: rtl/fp_coproc_pkg.sv
// Shared types and constants for the memory-mapped floating-point coprocessors.
// Holds FSM state encoding, register offsets, status bit positions and IEEE-754 constants.
package fp_coproc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MULT   = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4
  } state_t;

  localparam logic [1:0] REG_OPA  = 2'd0;
  localparam logic [1:0] REG_OPB  = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_RES  = 2'd3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;
  localparam int STAT_UNF  = 3;
  localparam int STAT_INV  = 4;

  localparam logic [9:0]  EXP_BIAS = 10'd127;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

endpackage

// File: rtl/fp_mant_mul.sv
// Iterative shift-add significand multiplier: one partial product per step.
// `last` flags the step that completes the product; `done` is its registered echo.
module fp_mant_mul #(
  parameter int MUL_CYCLES = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [23:0] mcand,
  input  logic [23:0] mplier,
  output logic [47:0] product,
  output logic        last,
  output logic        done
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic [47:0] cand;
  logic [23:0] plier;
  logic [47:0] acc;
  logic [CW-1:0] cnt;

  assign product = acc;
  assign last    = step && (cnt == CW'(MUL_CYCLES - 1));

  // Multiplicand shifts left while the multiplier is consumed LSB first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand  <= 48'd0;
      plier <= 24'd0;
      acc   <= 48'd0;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (load) begin
      cand  <= {24'd0, mcand};
      plier <= mplier;
      acc   <= 48'd0;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (step && !done) begin
      acc   <= acc + (plier[0] ? cand : 48'd0);
      cand  <= {cand[46:0], 1'b0};
      plier <= {1'b0, plier[23:1]};
      cnt   <= cnt + CW'(1);
      done  <= last;
    end else begin
      done  <= done;
    end
  end

endmodule

// File: rtl/fp_mul_coproc.sv
// Memory-mapped IEEE-754 single-precision multiplier coprocessor.
// Special operands resolve in UNPACK; normal operands go through shift-add, normalize, round.
module fp_mul_coproc
  import fp_coproc_pkg::*;
#(
  parameter int MUL_CYCLES = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  state_t state, next;

  logic [31:0] opa, opb, result;
  logic        done, ovf, unf, inv;
  logic        sign;
  logic signed [9:0] exp;
  logic [47:0] prod;
  logic        is_special, spec_inv;
  logic [31:0] spec_val;

  logic        mul_load, mul_step, mul_last, mul_done;
  logic [47:0] mul_product;

  logic wr, busy, start;
  assign wr    = cs & we;
  assign busy  = (state != IDLE);
  assign start = wr && (a[3:2] == REG_CTRL) && wd[0] && !busy;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        u_sign, u_special, u_inv;
  logic [9:0]  u_exp;
  logic [31:0] u_val;

  assign ea     = opa[30:23];
  assign eb     = opb[30:23];
  assign fa     = opa[22:0];
  assign fb     = opb[22:0];
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign u_sign = opa[31] ^ opb[31];
  assign u_exp  = {2'b00, ea} + {2'b00, eb} - EXP_BIAS;

  // Special-case classification; exponent-zero inputs count as zero.
  always_comb begin
    u_special = 1'b0;
    u_inv     = 1'b0;
    u_val     = 32'd0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      u_special = 1'b1;
      u_inv     = 1'b1;
      u_val     = QNAN;
    end else if (a_inf || b_inf) begin
      u_special = 1'b1;
      u_val     = {u_sign, POS_INF[30:0]};
    end else if (a_zero || b_zero) begin
      u_special = 1'b1;
      u_val     = {u_sign, 31'd0};
    end else begin
      u_special = 1'b0;
    end
  end

  fp_mant_mul #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .step    (mul_step),
    .mcand   ({1'b1, fa}),
    .mplier  ({1'b1, fb}),
    .product (mul_product),
    .last    (mul_last),
    .done    (mul_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next     = state;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state)
      IDLE: begin
        if (start) next = UNPACK;
        else       next = IDLE;
      end
      UNPACK: begin
        mul_load = 1'b1;
        if (u_special) next = ROUND;
        else           next = MULT;
      end
      MULT: begin
        mul_step = 1'b1;
        if (mul_last) next = NORM;
        else          next = MULT;
      end
      NORM:    next = ROUND;
      ROUND:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  logic [22:0] frac;
  logic        round_up;
  logic [23:0] mant;
  logic signed [9:0] r_exp;
  logic [31:0] r_val;
  logic        r_ovf, r_unf;

  // Nearest-even rounding: guard at bit 22, sticky below it, lsb at bit 23.
  always_comb begin
    frac     = prod[45:23];
    round_up = prod[22] & ((|prod[21:0]) | prod[23]);
    mant     = {1'b0, frac} + {23'd0, round_up};
    r_exp    = exp + $signed({9'd0, mant[23]});
    r_ovf    = 1'b0;
    r_unf    = 1'b0;
    r_val    = 32'd0;
    if (r_exp >= 10'sd255) begin
      r_ovf = 1'b1;
      r_val = {sign, POS_INF[30:0]};
    end else if (r_exp <= 10'sd0) begin
      r_unf = 1'b1;
      r_val = {sign, 31'd0};
    end else begin
      r_val = {sign, r_exp[7:0], mant[22:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa        <= 32'd0;
      opb        <= 32'd0;
      result     <= 32'd0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      inv        <= 1'b0;
      sign       <= 1'b0;
      exp        <= 10'sd0;
      prod       <= 48'd0;
      is_special <= 1'b0;
      spec_inv   <= 1'b0;
      spec_val   <= 32'd0;
    end else begin
      if (wr && !busy) begin
        case (a[3:2])
          REG_OPA: opa <= wd;
          REG_OPB: opb <= wd;
          default: ;
        endcase
      end
      if (start) begin
        done <= 1'b0;
        ovf  <= 1'b0;
        unf  <= 1'b0;
        inv  <= 1'b0;
      end
      case (state)
        UNPACK: begin
          sign       <= u_sign;
          exp        <= $signed(u_exp);
          is_special <= u_special;
          spec_inv   <= u_inv;
          spec_val   <= u_val;
        end
        NORM: begin
          prod <= mul_product[47] ? {1'b0, mul_product[47:1]} : mul_product;
          exp  <= exp + (mul_product[47] ? 10'sd1 : 10'sd0);
        end
        ROUND: begin
          done <= 1'b1;
          if (is_special) begin
            result <= spec_val;
            inv    <= spec_inv;
          end else begin
            result <= r_val;
            ovf    <= r_ovf;
            unf    <= r_unf;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (a[3:2])
      REG_OPA:  rd = opa;
      REG_OPB:  rd = opb;
      REG_CTRL: rd = {27'd0, inv, unf, ovf, done, busy};
      REG_RES:  rd = result;
      default:  rd = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_fp_mul_coproc.sv
// Self-checking bench: directed bus scenarios plus random operands against a
// behavioural single-precision multiply model built from integer arithmetic.
module tb_fp_mul_coproc;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, we;
  logic [31:0] a, wd, rd;

  int checks = 0;
  int errors = 0;

  fp_mul_coproc #(.MUL_CYCLES(24)) dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] addr_of(input logic [1:0] idx);
    return {16'h0000, 12'h04C, idx, 2'b00};
  endfunction

  task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; a = addr_of(idx); wd = data;
    @(posedge clk);
    #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] idx, output logic [31:0] data);
    a = addr_of(idx);
    #1;
    data = rd;
  endtask

  task automatic wait_done(output int n);
    logic [31:0] s;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      bus_read(2'd2, s);
      if (s[1]) begin
        n = i;
        break;
      end
    end
  endtask

  // Reference: value-level IEEE single multiply with the coprocessor's flush/round rules.
  task automatic ref_mul(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output logic [31:0] st, output int lat);
    int ex, ey, e;
    longint fx, fy, p, frac, rem;
    logic s, nx, ny, ix, iy, zx, zy;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    fx = longint'(x[22:0]); fy = longint'(y[22:0]);
    s  = x[31] ^ y[31];
    nx = (ex == 255) && (fx != 0); ny = (ey == 255) && (fy != 0);
    ix = (ex == 255) && (fx == 0); iy = (ey == 255) && (fy == 0);
    zx = (ex == 0); zy = (ey == 0);
    lat = 2; st = 32'h2;
    if (nx || ny || (ix && zy) || (zx && iy)) begin
      res = 32'h7FC00000; st = 32'h12;
    end else if (ix || iy) begin
      res = {s, 31'h7F800000};
    end else if (zx || zy) begin
      res = {s, 31'd0};
    end else begin
      lat = 27;
      p = (fx + 64'd8388608) * (fy + 64'd8388608);
      e = ex + ey - 127;
      if (p >= 64'h8000_0000_0000) begin
        p = p / 2;
        e = e + 1;
      end
      frac = (p / 64'd8388608) % 64'd8388608;
      rem  = p % 64'd8388608;
      if (rem > 64'd4194304 || (rem == 64'd4194304 && (frac % 2) == 1)) frac = frac + 1;
      if (frac == 64'd8388608) begin
        frac = 0;
        e = e + 1;
      end
      if (e >= 255) begin
        res = {s, 31'h7F800000}; st = 32'h6;
      end else if (e <= 0) begin
        res = {s, 31'd0}; st = 32'hA;
      end else begin
        res = {s, e[7:0], frac[22:0]};
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er, es, s;
    int el, n;
    ref_mul(x, y, er, es, el);
    bus_write(2'd0, x);
    bus_write(2'd1, y);
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, s);
    check({tag, "_stat_busy"}, s, 32'h1);
    wait_done(n);
    check({tag, "_latency"}, n, el);
    bus_read(2'd3, s);
    check({tag, "_result"}, s, er);
    bus_read(2'd2, s);
    check({tag, "_stat"}, s, es);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    logic [22:0] f;
    int mode;
    mode = int'($urandom_range(0, 7));
    case (mode)
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'($urandom_range(1, 40));
      3:       e = 8'($urandom_range(215, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  initial begin
    logic [31:0] v;
    int n;
    reset = 1'b1; cs = 1'b0; we = 1'b0; a = 32'd0; wd = 32'd0;
    #1;
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), v);
      check($sformatf("reset_rd%0d", i), v, 32'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_read(2'd2, v);
    check("post_reset_stat", v, 32'd0);

    run_op("mul_3p75", 32'h3FC00000, 32'h40200000);
    bus_read(2'd3, v); check("mul_3p75_const", v, 32'h40700000);
    bus_read(2'd2, v); check("mul_3p75_stat_const", v, 32'h2);
    run_op("sign", 32'h40400000, 32'hBF000000);
    bus_read(2'd3, v); check("sign_const", v, 32'hBFC00000);
    run_op("round", 32'h3F800001, 32'h3F800001);
    bus_read(2'd3, v); check("round_const", v, 32'h3F800002);
    run_op("ovf", 32'h7F000000, 32'h7F000000);
    bus_read(2'd3, v); check("ovf_const", v, 32'h7F800000);
    bus_read(2'd2, v); check("ovf_stat_const", v, 32'h6);
    run_op("inf_x_zero", 32'h7F800000, 32'h00000000);
    bus_read(2'd3, v); check("inf_x_zero_const", v, 32'h7FC00000);
    bus_read(2'd2, v); check("inf_x_zero_stat_const", v, 32'h12);
    run_op("unf", 32'h00800000, 32'h00800000);
    run_op("tie_even", 32'h3FC00001, 32'h3FFFFFFE);

    // Writes while busy are ignored; the running operation is unaffected.
    bus_write(2'd0, 32'h3FC00000);
    bus_write(2'd1, 32'h40200000);
    bus_write(2'd2, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    bus_write(2'd0, 32'h12345678);
    bus_write(2'd1, 32'h00000000);
    bus_write(2'd2, 32'h1);
    bus_read(2'd0, v); check("busy_opa_kept", v, 32'h3FC00000);
    bus_read(2'd1, v); check("busy_opb_kept", v, 32'h40200000);
    wait_done(n);
    check("busy_latency", n, 19);
    bus_read(2'd3, v); check("busy_result", v, 32'h40700000);

    // Reset ten edges into an operation wipes everything.
    bus_write(2'd0, 32'h40400000);
    bus_write(2'd1, 32'h40400000);
    bus_write(2'd2, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), v);
      check($sformatf("midop_reset_rd%0d", i), v, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op("after_reset", 32'h40400000, 32'h40400000);
    bus_read(2'd3, v); check("after_reset_const", v, 32'h41100000);

    // A start landing on the ROUND->IDLE edge is dropped.
    bus_write(2'd0, 32'h3F800000);
    bus_write(2'd1, 32'h40000000);
    bus_write(2'd2, 32'h1);
    repeat (26) @(posedge clk);
    #1;
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, v); check("late_start_stat", v, 32'h2);
    @(posedge clk);
    #1;
    bus_read(2'd2, v); check("late_start_idle", v, 32'h2);
    bus_read(2'd3, v); check("late_start_result", v, 32'h40000000);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), rand_fp(), rand_fp());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
